// File: rtl/cpu_clken_gen_if.sv
// Configuration and clock-enable output bundle for cpu_clken_gen.
// The master drives the configuration; the slave (the generator) drives the channel outputs.
interface cpu_clken_gen_if #(
  parameter int NUM_CLOCKS = 4,
  parameter int DIV_WIDTH  = 8
);
  logic                             cfg_load;
  logic [NUM_CLOCKS*DIV_WIDTH-1:0]  cfg_div;
  logic [NUM_CLOCKS*DIV_WIDTH-1:0]  cfg_phase;
  logic [NUM_CLOCKS-1:0]            outclk_en;
  logic [NUM_CLOCKS-1:0]            outclk_sq;
  logic                             locked;

  modport master (
    output cfg_load, cfg_div, cfg_phase,
    input  outclk_en, outclk_sq, locked
  );

  modport slave (
    input  cfg_load, cfg_div, cfg_phase,
    output outclk_en, outclk_sq, locked
  );
endinterface

// File: rtl/cpu_clken_gen.sv
// Multi-channel clock-enable / square-wave generator with programmable divide and phase.
// Every reset or reconfiguration goes through a settle interval before the channels run.
//
//  state  | meaning
//  SETTLE | settle counter running, channel counters parked at phase, outputs held low
//  RUN    | locked; each channel counts modulo its divide ratio
module cpu_clken_gen #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic           refclk,
  input  logic           rst_n,
  cpu_clken_gen_if.slave bus
);
  localparam int SCW = $clog2(LOCK_CYCLES) + 1;

  typedef enum logic {SETTLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [SCW-1:0]         sc;
  logic [DIV_WIDTH-1:0]   div_r   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   ph_r    [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   cnt     [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   div_eff [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   ph_eff  [NUM_CLOCKS];
  logic [DIV_WIDTH:0]     sq_half [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0]  en_v, sq_v;
  logic                   locked_v;

  // Divide 0 runs as divide 1; an out-of-range phase falls back to 0.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      div_eff[i] = (div_r[i] == '0) ? DIV_WIDTH'(1) : div_r[i];
      ph_eff[i]  = (ph_r[i] >= div_eff[i]) ? '0 : ph_r[i];
      sq_half[i] = ({1'b0, div_eff[i]} + (DIV_WIDTH+1)'(1)) >> 1;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) state <= SETTLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SETTLE:  if (sc == SCW'(LOCK_CYCLES - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = SETTLE;
    endcase
    if (bus.cfg_load) state_nxt = SETTLE;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sc <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_r[i] <= DIV_WIDTH'(DEFAULT_DIV);
        ph_r[i]  <= '0;
        cnt[i]   <= '0;
      end
    end else if (bus.cfg_load) begin
      sc <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_r[i] <= bus.cfg_div[i*DIV_WIDTH +: DIV_WIDTH];
        ph_r[i]  <= bus.cfg_phase[i*DIV_WIDTH +: DIV_WIDTH];
        cnt[i]   <= ph_eff[i];
      end
    end else if (state == SETTLE) begin
      sc <= sc + SCW'(1);
      for (int i = 0; i < NUM_CLOCKS; i++)
        cnt[i] <= ph_eff[i];
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++)
        cnt[i] <= (cnt[i] == div_eff[i] - DIV_WIDTH'(1)) ? '0 : cnt[i] + DIV_WIDTH'(1);
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    locked_v = (state == RUN);
    en_v     = '0;
    sq_v     = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      en_v[i] = locked_v & (cnt[i] == div_eff[i] - DIV_WIDTH'(1));
      sq_v[i] = locked_v & ({1'b0, cnt[i]} < sq_half[i]);
    end
  end

  assign bus.locked    = locked_v;
  assign bus.outclk_en = en_v;
  assign bus.outclk_sq = sq_v;
endmodule

// File: tb/tb_cpu_clken_gen.sv
// Scoreboard bench for cpu_clken_gen: a closed-form timing model pushes the expected
// lock/enable/square state per cycle, and the monitor pops and compares after each edge.
module tb_cpu_clken_gen;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int LOCK = 16;
  localparam int DDIV = 2;

  typedef struct {
    logic         lk;
    logic [N-1:0] en;
    logic [N-1:0] sq;
    int           cyc;
  } exp_t;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;

  cpu_clken_gen_if #(.NUM_CLOCKS(N), .DIV_WIDTH(W)) bus ();

  cpu_clken_gen #(
    .NUM_CLOCKS(N), .DIV_WIDTH(W), .LOCK_CYCLES(LOCK), .DEFAULT_DIV(DDIV)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // model state
  int   k = 0;
  int   mdiv [N];
  int   mph  [N];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.lk  = (k >= LOCK);
    e.en  = '0;
    e.sq  = '0;
    e.cyc = cyc;
    if (e.lk) begin
      for (int i = 0; i < N; i++) begin
        int de, pe, c;
        de = (mdiv[i] == 0) ? 1 : mdiv[i];
        pe = (mph[i] >= de) ? 0 : mph[i];
        c  = (pe + (k - LOCK)) % de;
        e.en[i] = (c == de - 1);
        e.sq[i] = (c < (de + 1) / 2);
      end
    end
    return e;
  endfunction

  // One clock: drive inputs, predict the post-edge outputs, then pop and compare.
  task automatic step(input bit rn, input bit ld, input logic [N*W-1:0] dv, input logic [N*W-1:0] ph);
    exp_t e;
    rst_n         = rn;
    bus.cfg_load  = ld;
    bus.cfg_div   = dv;
    bus.cfg_phase = ph;
    if (!rn) begin
      k = 0;
      for (int i = 0; i < N; i++) begin mdiv[i] = DDIV; mph[i] = 0; end
    end else if (ld) begin
      k = 0;
      for (int i = 0; i < N; i++) begin
        mdiv[i] = int'(dv[i*W +: W]);
        mph[i]  = int'(ph[i*W +: W]);
      end
    end else if (k < 100000) begin
      k++;
    end
    q.push_back(model_out());
    @(posedge refclk);
    #1;
    cyc++;
    e = q.pop_front();
    check_val($sformatf("locked@%0d", e.cyc), {31'b0, bus.locked}, {31'b0, e.lk});
    check_val($sformatf("outclk_en@%0d", e.cyc), {28'b0, bus.outclk_en}, {28'b0, e.en});
    check_val($sformatf("outclk_sq@%0d", e.cyc), {28'b0, bus.outclk_sq}, {28'b0, e.sq});
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b1, 1'b0, bus.cfg_div, bus.cfg_phase);
  endtask

  function automatic logic [N*W-1:0] pack4(input int c3, input int c2, input int c1, input int c0);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  initial begin
    logic [N*W-1:0] d, p;
    for (int i = 0; i < N; i++) begin mdiv[i] = DDIV; mph[i] = 0; end
    bus.cfg_load  = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_phase = '0;
    #2;

    // reset with a load strobe that must be ignored
    step(1'b0, 1'b1, pack4(5, 5, 5, 5), '0);
    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    idle(LOCK + 12);

    // ch0=7, ch1=3, ch2=2, ch3=1
    step(1'b1, 1'b1, pack4(1, 2, 3, 7), '0);
    idle(LOCK + 30);

    // phase offsets, ch0 div 8 phase 5
    step(1'b1, 1'b1, pack4(3, 4, 5, 8), pack4(1, 3, 2, 5));
    idle(LOCK + 30);

    // reconfigure mid-RUN, then again at settle cycle 10
    step(1'b1, 1'b1, pack4(6, 2, 9, 4), pack4(0, 1, 4, 2));
    idle(10);
    step(1'b1, 1'b1, pack4(2, 5, 3, 6), pack4(1, 0, 2, 3));
    idle(LOCK + 24);

    // div 0 -> 1, out-of-range phase -> 0
    step(1'b1, 1'b1, pack4(2, 6, 4, 0), pack4(1, 6, 9, 0));
    idle(LOCK + 20);

    // one-cycle reset with simultaneous load
    step(1'b0, 1'b1, pack4(9, 9, 9, 9), pack4(3, 3, 3, 3));
    idle(LOCK + 20);

    // random configurations, some reloaded during settle
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        d[i*W +: W] = W'($urandom_range(0, 12));
        p[i*W +: W] = W'($urandom_range(0, 12));
      end
      step(1'b1, 1'b1, d, p);
      idle(int'($urandom_range(3, LOCK + 25)));
    end

    // full-range divide
    step(1'b1, 1'b1, pack4(255, 254, 1, 255), pack4(0, 253, 0, 250));
    idle(LOCK + 12);

    check_val("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
